// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow and selectable registered or fall-through read.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       write_en,
  input  logic                       read_en,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    write_ptr;
  logic [PW-1:0]    read_ptr;
  logic [CW-1:0]    count;
  logic             wr_acc;
  logic             rd_acc;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign fifo_full    = (count == CNT_FULL);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (int'(count) >= AF_THRESH);
  assign almost_empty = (int'(count) <= AE_THRESH);
  assign fifo_count   = count;

  assign wr_acc = write_en & ~fifo_full;
  assign rd_acc = read_en & ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) write_ptr <= ptr_next(write_ptr);
      if (rd_acc) read_ptr  <= ptr_next(read_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new error on the same edge as clr_err keeps the flag set.
      if (write_en && fifo_full) overflow <= 1'b1;
      else if (clr_err)          overflow <= 1'b0;
      if (read_en && fifo_empty) underflow <= 1'b1;
      else if (clr_err)          underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[write_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[read_ptr];
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         data_out <= '0;
        else if (rd_acc) data_out <= mem[read_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: three FIFO configurations checked against a queue model.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data_in = '0;
  logic write_en = 1'b0, read_en = 1'b0, clr_err = 1'b0;

  logic [2:0]      full_v, empty_v, af_v, ae_v, ovf_v, unf_v;
  logic [2:0][7:0] dout_v;
  logic [4:0]      cnt0, cnt2;
  logic [2:0]      cnt1;

  always #5 clk = ~clk;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_d16 (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
    .clr_err(clr_err), .data_out(dout_v[0]), .fifo_full(full_v[0]), .fifo_empty(empty_v[0]),
    .almost_full(af_v[0]), .almost_empty(ae_v[0]), .fifo_count(cnt0),
    .overflow(ovf_v[0]), .underflow(unf_v[0]));

  sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_d5 (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
    .clr_err(clr_err), .data_out(dout_v[1]), .fifo_full(full_v[1]), .fifo_empty(empty_v[1]),
    .almost_full(af_v[1]), .almost_empty(ae_v[1]), .fifo_count(cnt1),
    .overflow(ovf_v[1]), .underflow(unf_v[1]));

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
    .clr_err(clr_err), .data_out(dout_v[2]), .fifo_full(full_v[2]), .fifo_empty(empty_v[2]),
    .almost_full(af_v[2]), .almost_empty(ae_v[2]), .fifo_count(cnt2),
    .overflow(ovf_v[2]), .underflow(unf_v[2]));

  typedef struct {
    int cyc; int k; int cnt;
    bit full; bit empty; bit af; bit ae; bit ovf; bit unf;
    bit dchk; logic [7:0] data;
  } rec_t;

  rec_t exp_q[$];
  logic [7:0] mq[$];
  bit m_ovf, m_unf;
  logic [7:0] m_dout;
  int act_k = 0;
  int cyc = 0;
  int vectors = 0, miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dep(int k);
    return (k == 1) ? 5 : 16;
  endfunction

  function automatic bit is_fwft(int k);
    return k == 2;
  endfunction

  function automatic int cnt_of(int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic void chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s (inst %0d, t=%0t): got %0h expected %0h", nm, act_k, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    rec_t r;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      r = exp_q.pop_front();
      chk("count", cnt_of(r.k), r.cnt);
      chk("full", int'(full_v[r.k]), int'(r.full));
      chk("empty", int'(empty_v[r.k]), int'(r.empty));
      chk("almost_full", int'(af_v[r.k]), int'(r.af));
      chk("almost_empty", int'(ae_v[r.k]), int'(r.ae));
      chk("overflow", int'(ovf_v[r.k]), int'(r.ovf));
      chk("underflow", int'(unf_v[r.k]), int'(r.unf));
      if (r.dchk) chk("data_out", int'(dout_v[r.k]), int'(r.data));
    end
  end

  // Drive one cycle and queue the state expected after the coming edge.
  task automatic step(bit we, bit re, bit ce, logic [7:0] d);
    rec_t r;
    int dp;
    bit wa, ra;
    logic [7:0] tmp;
    @(negedge clk);
    write_en = we; read_en = re; clr_err = ce; data_in = d;
    dp = dep(act_k);
    wa = we && (mq.size() < dp);
    ra = re && (mq.size() > 0);
    if (we && mq.size() == dp) m_ovf = 1'b1;
    else if (ce)               m_ovf = 1'b0;
    if (re && mq.size() == 0)  m_unf = 1'b1;
    else if (ce)               m_unf = 1'b0;
    if (ra) begin
      tmp = mq.pop_front();
      if (!is_fwft(act_k)) m_dout = tmp;
    end
    if (wa) mq.push_back(d);
    r.cyc = cyc + 1;
    r.k = act_k;
    r.cnt = mq.size();
    r.full = (r.cnt == dp);
    r.empty = (r.cnt == 0);
    r.af = (r.cnt >= dp - 2);
    r.ae = (r.cnt <= 2);
    r.ovf = m_ovf;
    r.unf = m_unf;
    if (is_fwft(act_k)) begin
      r.dchk = (r.cnt > 0);
      r.data = (r.cnt > 0) ? mq[0] : 8'h00;
    end else begin
      r.dchk = 1'b1;
      r.data = m_dout;
    end
    exp_q.push_back(r);
  endtask

  // Reset lands between edges; the outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    write_en = 1'b0; read_en = 1'b0; clr_err = 1'b0;
    rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dout = 8'h00;
    #1;
    chk("rst_count", cnt_of(act_k), 0);
    chk("rst_empty", int'(empty_v[act_k]), 1);
    chk("rst_full", int'(full_v[act_k]), 0);
    chk("rst_almost_empty", int'(ae_v[act_k]), 1);
    chk("rst_almost_full", int'(af_v[act_k]), 0);
    chk("rst_overflow", int'(ovf_v[act_k]), 0);
    chk("rst_underflow", int'(unf_v[act_k]), 0);
    if (!is_fwft(act_k)) chk("rst_data_out", int'(dout_v[act_k]), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic rnd(int n);
    int p;
    for (int i = 0; i < n; i++) begin
      p = ((i / 40) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < p, $urandom_range(0, 99) < (100 - p),
           $urandom_range(0, 15) == 0, 8'($urandom));
    end
  endtask

  initial begin
    // Depth 16, registered read
    act_k = 0;
    do_reset();
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++) step(1, 0, 0, 8'(i));
    step(1, 0, 0, 8'h11);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) step(1, 1, 0, 8'($urandom));
    while (mq.size() < 16) step(1, 0, 0, 8'($urandom));
    step(1, 1, 0, 8'($urandom));
    while (mq.size() > 0) step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'($urandom));
    step(0, 0, 1, 8'h00);
    rnd(400);

    // Depth 5: pointer wrap on a non-power-of-two depth
    act_k = 1;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) step(1, 0, 0, 8'(8'hA0 + r * 3 + j));
      for (int j = 0; j < 3; j++) step(0, 1, 0, 8'h00);
    end
    rnd(300);

    // Depth 16, first-word-fall-through
    act_k = 2;
    do_reset();
    step(1, 0, 0, 8'h55);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 8'($urandom));
    do_reset();
    step(1, 0, 0, 8'h3C);
    step(0, 0, 0, 8'h00);
    rnd(300);

    step(0, 0, 0, 8'h00);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
